// File: rtl/int_pkg.sv
// Shared constants and types for the interrupt delegation/arbitration slice:
// standard cause codes, their fixed priority order and the arbiter state enum.
package int_pkg;

  localparam int unsigned CAUSE_SSI = 1;
  localparam int unsigned CAUSE_MSI = 3;
  localparam int unsigned CAUSE_STI = 5;
  localparam int unsigned CAUSE_MTI = 7;
  localparam int unsigned CAUSE_SEI = 9;
  localparam int unsigned CAUSE_MEI = 11;

  localparam int unsigned NUM_STD_PRIO = 6;
  localparam int unsigned FIRST_LOCAL  = 12;

  // Entry [NUM_STD_PRIO-1] is the highest priority, entry [0] the lowest.
  localparam logic [NUM_STD_PRIO-1:0][3:0] STD_PRIO = {
    4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/int_prio_sel.sv
// Fixed-priority picker: standard causes first (11,3,7,9,1,5), then local
// causes >= 12 with the higher index winning. Reserved indices are ignored.
module int_prio_sel
  import int_pkg::*;
#(
  parameter int unsigned NUM_INT = 16,
  parameter int unsigned IDX_W   = $clog2(NUM_INT)
) (
  input  logic [NUM_INT-1:0] cand_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Later assignments override earlier ones, so walk from lowest to highest priority.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = FIRST_LOCAL; i < NUM_INT; i++) begin
      valid_o = valid_o | cand_i[IDX_W'(i)];
      idx_o   = cand_i[IDX_W'(i)] ? IDX_W'(i) : idx_o;
    end
    for (int unsigned k = 0; k < NUM_STD_PRIO; k++) begin
      valid_o = valid_o | cand_i[IDX_W'(STD_PRIO[k])];
      idx_o   = cand_i[IDX_W'(STD_PRIO[k])] ? IDX_W'(STD_PRIO[k]) : idx_o;
    end
  end

endmodule

// File: rtl/int_deleg_arbiter.sv
// Interrupt delegation and arbitration: owns mideleg, latches edge sources,
// qualifies candidates per privilege and presents one frozen request to the trap unit.
module int_deleg_arbiter
  import int_pkg::*;
#(
  parameter int unsigned       XLEN       = 64,
  parameter int unsigned       NUM_INT    = 16,
  parameter logic [NUM_INT-1:0] DELEG_MASK = NUM_INT'(16'h0222),
  parameter logic [NUM_INT-1:0] EDGE_MASK  = NUM_INT'(16'h0000)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] irq_line,
  input  logic [NUM_INT-1:0] sw_ip,
  input  logic [NUM_INT-1:0] ie,
  input  logic               mstatus_mie,
  input  logic               mstatus_sie,
  input  logic [3:0]         priv,
  input  logic               csr_write,
  input  logic               mideleg_sel,
  input  logic [XLEN-1:0]    data_csr,
  output logic [XLEN-1:0]    mideleg,
  output logic               int_req,
  output logic [XLEN-1:0]    int_cause,
  output logic               int_target_m,
  output logic               int_target_s,
  input  logic               int_ack
);

  localparam int unsigned IDX_W = $clog2(NUM_INT);

  logic [NUM_INT-1:0] mideleg_q, mideleg_d;
  logic [NUM_INT-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_INT-1:0] line_q;
  arb_state_e         state_q;
  logic               int_req_q, tgt_m_q, tgt_s_q;
  logic [IDX_W-1:0]   cause_idx_q;
  logic [XLEN-1:0]    int_cause_q;

  logic [NUM_INT-1:0] pend_s, cand_s, m_cand_s, s_cand_s, ack_clr_s;
  logic               m_en_s, s_en_s, m_valid_s, s_valid_s, src_qual_s;
  logic [IDX_W-1:0]   m_idx_s, s_idx_s, win_idx_s;
  logic [XLEN-1:0]    win_cause_s;
  logic               unused_s;

  assign unused_s = ^{data_csr[XLEN-1:NUM_INT], priv[2]};

  // Pending/candidate vectors, qualification and next values of the CSR-side registers.
  always_comb begin
    pend_s   = sw_ip | (irq_line & ~EDGE_MASK) | (edge_pend_q & EDGE_MASK);
    cand_s   = pend_s & ie;
    m_en_s   = ~priv[3] | mstatus_mie;
    s_en_s   = ~priv[3] & (priv[0] | (priv[1] & mstatus_sie));
    m_cand_s = m_en_s ? (cand_s & ~mideleg_q) : '0;
    s_cand_s = s_en_s ? (cand_s & mideleg_q) : '0;
    // The frozen request stays alive only while its own source still qualifies.
    src_qual_s = cand_s[cause_idx_q] &
                 (tgt_m_q ? (~mideleg_q[cause_idx_q] & m_en_s)
                          : (mideleg_q[cause_idx_q] & s_en_s));
    ack_clr_s   = ((state_q == REQ) && int_ack) ?
                  ({{(NUM_INT-1){1'b0}}, 1'b1} << cause_idx_q) : '0;
    edge_pend_d = ((edge_pend_q & ~ack_clr_s) | (irq_line & ~line_q)) & EDGE_MASK;
    mideleg_d   = (csr_write & mideleg_sel) ? (data_csr[NUM_INT-1:0] & DELEG_MASK)
                                            : mideleg_q;
    win_idx_s   = m_valid_s ? m_idx_s : s_idx_s;
    win_cause_s = '0;
    win_cause_s[XLEN-1]    = 1'b1;
    win_cause_s[IDX_W-1:0] = win_idx_s;
  end

  int_prio_sel #(.NUM_INT(NUM_INT), .IDX_W(IDX_W)) u_sel_m (
    .cand_i (m_cand_s),
    .valid_o(m_valid_s),
    .idx_o  (m_idx_s)
  );

  int_prio_sel #(.NUM_INT(NUM_INT), .IDX_W(IDX_W)) u_sel_s (
    .cand_i (s_cand_s),
    .valid_o(s_valid_s),
    .idx_o  (s_idx_s)
  );

  // mideleg, edge latches and line history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mideleg_q   <= '0;
      edge_pend_q <= '0;
      line_q      <= '0;
    end else begin
      mideleg_q   <= mideleg_d;
      edge_pend_q <= edge_pend_d;
      line_q      <= irq_line;
    end
  end

  // Request FSM with registered outputs; an enabled M winner pre-empts any S winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      int_req_q   <= 1'b0;
      int_cause_q <= '0;
      tgt_m_q     <= 1'b0;
      tgt_s_q     <= 1'b0;
      cause_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_valid_s | s_valid_s) begin
            state_q     <= REQ;
            int_req_q   <= 1'b1;
            int_cause_q <= win_cause_s;
            tgt_m_q     <= m_valid_s;
            tgt_s_q     <= ~m_valid_s;
            cause_idx_q <= win_idx_s;
          end else begin
            state_q     <= IDLE;
            int_req_q   <= 1'b0;
            int_cause_q <= '0;
            tgt_m_q     <= 1'b0;
            tgt_s_q     <= 1'b0;
          end
        end
        REQ: begin
          if (int_ack || !src_qual_s) begin
            state_q     <= int_ack ? HOLD : IDLE;
            int_req_q   <= 1'b0;
            int_cause_q <= '0;
            tgt_m_q     <= 1'b0;
            tgt_s_q     <= 1'b0;
          end else begin
            state_q <= REQ;
          end
        end
        HOLD: begin
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          int_req_q   <= 1'b0;
          int_cause_q <= '0;
          tgt_m_q     <= 1'b0;
          tgt_s_q     <= 1'b0;
        end
      endcase
    end
  end

  assign mideleg      = {{(XLEN-NUM_INT){1'b0}}, mideleg_q};
  assign int_req      = int_req_q;
  assign int_cause    = int_cause_q;
  assign int_target_m = tgt_m_q;
  assign int_target_s = tgt_s_q;

endmodule

// File: tb/tb_int_deleg_arbiter.sv
// Bench for int_deleg_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural model of the delegation rules.
module tb_int_deleg_arbiter;

  localparam bit [15:0] EM = 16'h1000;
  localparam bit [15:0] DM = 16'h0222;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_line, sw_ip, ie;
  logic        mstatus_mie, mstatus_sie;
  logic [3:0]  priv;
  logic        csr_write, mideleg_sel, int_ack;
  logic [63:0] data_csr;
  logic [63:0] mideleg, int_cause;
  logic        int_req, int_target_m, int_target_s;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [15:0] md_mdg, md_epend, md_prev;
  bit        md_req, md_hold, md_tm;
  int        md_cause;

  int_deleg_arbiter #(.XLEN(64), .NUM_INT(16), .DELEG_MASK(16'h0222), .EDGE_MASK(EM)) dut (
    .clk(clk), .rst(rst), .irq_line(irq_line), .sw_ip(sw_ip), .ie(ie),
    .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie), .priv(priv),
    .csr_write(csr_write), .mideleg_sel(mideleg_sel), .data_csr(data_csr),
    .mideleg(mideleg), .int_req(int_req), .int_cause(int_cause),
    .int_target_m(int_target_m), .int_target_s(int_target_s), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Lower rank = higher priority; -1 = never selectable.
  function automatic int rank(input int i);
    if (i >= 12) return 6 + (15 - i);
    case (i)
      11: return 0;
      3:  return 1;
      7:  return 2;
      9:  return 3;
      1:  return 4;
      5:  return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int pick(input bit [15:0] v);
    int best = -1;
    for (int i = 0; i < 16; i++)
      if (v[i] && rank(i) >= 0 && (best < 0 || rank(i) < rank(best))) best = i;
    return best;
  endfunction

  task automatic model_reset();
    md_mdg = '0; md_epend = '0; md_prev = '0;
    md_req = 1'b0; md_hold = 1'b0; md_tm = 1'b0; md_cause = 0;
  endtask

  task automatic drive_idle();
    irq_line = '0; sw_ip = '0; ie = '0; mstatus_mie = 1'b0; mstatus_sie = 1'b0;
    priv = 4'b1000; csr_write = 1'b0; mideleg_sel = 1'b0; data_csr = '0; int_ack = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit [15:0] pend, cand, clr;
    bit men, sen, qual;
    int mw, sw;
    pend = sw_ip | (irq_line & ~EM) | (md_epend & EM);
    cand = pend & ie;
    men  = !priv[3] || mstatus_mie;
    sen  = !priv[3] && (priv[0] || (priv[1] && mstatus_sie));
    mw   = men ? pick(cand & ~md_mdg) : -1;
    sw   = sen ? pick(cand & md_mdg) : -1;
    clr  = '0;
    if (md_hold) begin
      md_hold = 1'b0;
    end else if (md_req) begin
      if (int_ack) begin
        md_req = 1'b0; md_hold = 1'b1; clr[md_cause] = 1'b1;
      end else begin
        qual = cand[md_cause] && (md_tm ? (!md_mdg[md_cause] && men)
                                        : (md_mdg[md_cause] && sen));
        if (!qual) md_req = 1'b0;
      end
    end else if (mw >= 0) begin
      md_req = 1'b1; md_tm = 1'b1; md_cause = mw;
    end else if (sw >= 0) begin
      md_req = 1'b1; md_tm = 1'b0; md_cause = sw;
    end
    md_epend = (md_epend & ~clr) | (irq_line & ~md_prev & EM);
    md_prev  = irq_line;
    if (csr_write && mideleg_sel) md_mdg = data_csr[15:0] & DM;
  endtask

  task automatic check_all(input string tag);
    logic [63:0] exp_cause;
    exp_cause = md_req ? (64'h8000_0000_0000_0000 | 64'(md_cause)) : 64'h0;
    chk({tag, ".req"},   {63'h0, int_req},      {63'h0, md_req});
    chk({tag, ".cause"}, int_cause,             exp_cause);
    chk({tag, ".tgt_m"}, {63'h0, int_target_m}, {63'h0, md_req && md_tm});
    chk({tag, ".tgt_s"}, {63'h0, int_target_s}, {63'h0, md_req && !md_tm});
    chk({tag, ".mdg"},   mideleg,               {48'h0, md_mdg});
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    drive_idle();
    model_reset();
    rst = 1'b0;
    #12;
    check_all("reset");
    rst = 1'b1;

    // mideleg write: only SSI/STI/SEI stick
    csr_write = 1'b1; mideleg_sel = 1'b1; data_csr = 64'hFFFF;
    step("mdg_wr");
    chk("mdg_wr_value", mideleg, 64'h0222);
    csr_write = 1'b0; mideleg_sel = 1'b0; data_csr = '0;

    // M priority in U-mode
    priv = 4'b0001; ie = 16'hFFFF; irq_line = 16'h0880;
    step("mprio");
    chk("mprio_cause", int_cause, 64'h8000_0000_0000_000B);
    chk("mprio_tgt_m", {63'h0, int_target_m}, 64'h1);
    int_ack = 1'b1; irq_line = 16'h0080;
    step("mprio_ack");
    int_ack = 1'b0;
    step("mprio_hold");
    chk("mprio_hold_req", {63'h0, int_req}, 64'h0);
    step("mprio_rereq");
    chk("mprio_rereq_cause", int_cause, 64'h8000_0000_0000_0007);
    int_ack = 1'b1; irq_line = '0;
    step("mprio_ack2");
    int_ack = 1'b0;
    step("mprio_idle");

    // Delegation of SEI
    csr_write = 1'b1; mideleg_sel = 1'b1; data_csr = 64'h200;
    step("deleg_wr");
    csr_write = 1'b0; mideleg_sel = 1'b0; data_csr = '0;
    priv = 4'b0010; mstatus_sie = 1'b1; irq_line = 16'h0200;
    step("deleg_s");
    chk("deleg_s_tgt", {63'h0, int_target_s}, 64'h1);
    chk("deleg_s_cause", int_cause, 64'h8000_0000_0000_0009);
    int_ack = 1'b1;
    step("deleg_ack");
    int_ack = 1'b0; priv = 4'b1000;
    repeat (3) step("deleg_mmode");
    chk("deleg_mmode_req", {63'h0, int_req}, 64'h0);
    priv = 4'b0010;
    step("deleg_s2");
    irq_line = 16'h0208;
    repeat (2) step("deleg_frozen");
    chk("deleg_frozen_cause", int_cause, 64'h8000_0000_0000_0009);
    int_ack = 1'b1; irq_line = '0;
    step("deleg_ack2");
    int_ack = 1'b0;
    step("deleg_done");

    // Withdrawal of a level MTI in M-mode
    priv = 4'b1000; mstatus_mie = 1'b1; irq_line = 16'h0080;
    step("wd_req");
    mstatus_mie = 1'b0;
    step("wd_fall");
    chk("wd_fall_req", {63'h0, int_req}, 64'h0);
    mstatus_mie = 1'b1;
    step("wd_req2");
    mstatus_mie = 1'b0; int_ack = 1'b1;
    step("wd_ackwins");
    int_ack = 1'b0; mstatus_mie = 1'b1;
    step("wd_hold");
    step("wd_rereq");
    int_ack = 1'b1; irq_line = '0;
    step("wd_ack");
    int_ack = 1'b0;
    step("wd_done");

    // Edge source on bit 12
    priv = 4'b0001;
    irq_line = 16'h1000;
    step("edge_pulse");
    irq_line = '0;
    step("edge_req");
    chk("edge_req_cause", int_cause, 64'h8000_0000_0000_000C);
    repeat (3) step("edge_persist");
    int_ack = 1'b1;
    step("edge_ack");
    int_ack = 1'b0;
    repeat (2) step("edge_clr");
    chk("edge_clr_req", {63'h0, int_req}, 64'h0);
    irq_line = 16'h1000;
    step("edge_pulse2");
    irq_line = '0;
    step("edge_req2");
    int_ack = 1'b1; irq_line = 16'h1000;
    step("edge_ack_set");
    int_ack = 1'b0; irq_line = '0;
    step("edge_hold");
    step("edge_rereq");
    chk("edge_rereq_req", {63'h0, int_req}, 64'h1);

    // Asynchronous reset while a request is up
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    drive_idle();
    check_all("async_rst");
    #3;
    rst = 1'b1;
    priv = 4'b0001; ie = 16'hFFFF;
    repeat (3) step("post_rst");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      irq_line    = 16'($urandom & $urandom & $urandom);
      sw_ip       = 16'($urandom & $urandom & $urandom & $urandom);
      ie          = 16'($urandom | $urandom);
      mstatus_mie = ($urandom_range(0, 3) != 0);
      mstatus_sie = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: priv = 4'b0001;
        1: priv = 4'b0010;
        default: priv = 4'b1000;
      endcase
      csr_write   = ($urandom_range(0, 15) == 0);
      mideleg_sel = ($urandom_range(0, 1) == 1);
      data_csr    = {$urandom, $urandom};
      int_ack     = md_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_deleg_arbiter.md
# int_deleg_arbiter

Parametrised interrupt delegation and arbitration unit for the CSR block: a successor to the fixed six-source mideleg logic. It owns the `mideleg` register and latches edge-type sources into a pending register. It qualifies every source against privilege and global enables, then presents one registered interrupt request, with a frozen cause and target, to the trap unit over a req/ack handshake. Only bits set in `DELEG_MASK` can be delegated to S-mode.

## Interface
- `XLEN`, 64: CSR data width.
- `NUM_INT`, 16: interrupt lines, bit index = cause code; must be ≥12 and ≤ XLEN-1.
- `DELEG_MASK`, 16'h0222: mideleg bits that are writable (SSI/STI/SEI); all other bits read 0.
- `EDGE_MASK`, 16'h0000: sources latched on a rising edge; all other sources are level-sensitive.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `irq_line` in NUM_INT: raw interrupt lines (external, timer, local).
- `sw_ip` in NUM_INT: software-writable mip/sip bits, level-sensitive.
- `ie` in NUM_INT: mie/sie enable bits.
- `mstatus_mie` in 1: global M interrupt enable.
- `mstatus_sie` in 1: global S interrupt enable.
- `priv` in 4: one-hot current privilege; [0]=U, [1]=S, [3]=M, [2] reserved.
- `csr_write` in 1: CSR write strobe.
- `mideleg_sel` in 1: CSR address decodes to mideleg.
- `data_csr` in XLEN: CSR write data.
- `mideleg` out XLEN: current mideleg value, zero-extended.
- `int_req` out 1: interrupt request to trap unit (registered).
- `int_cause` out XLEN: {1'b1, cause index} while `int_req` is high, else 0 (registered).
- `int_target_m` out 1: the taken interrupt traps to M.
- `int_target_s` out 1: the taken interrupt traps to S.
- `int_ack` in 1: one-cycle strobe from the trap unit; the trap has been taken.

## Operation
- **Pending vector.** Each bit is `sw_ip | irq_line` for level sources, or `sw_ip | edge_pend` for EDGE_MASK sources.
- **Edge latch.**
  - `edge_pend[i]` is set on a rising edge of `irq_line[i]`, detected against a registered copy of the line.
  - It is cleared when `int_ack` is high and `int_cause` equals i.
  - If a set and a clear occur in the same cycle, the set wins.
- **mideleg write.** `csr_write & mideleg_sel` loads `data_csr & DELEG_MASK`. The new value affects arbitration from the next cycle.
- **Qualification.** Let `cand[i] = pend[i] & ie[i]`.
  - M candidates are bits with `!mideleg[i]`. They are enabled when `!priv[3] | mstatus_mie`.
  - S candidates are bits with `mideleg[i]`. They are enabled when `priv[0] | (priv[1] & mstatus_sie)`, and never in M-mode.
  - Any enabled M candidate suppresses all S candidates.
- **Priority** within a target, highest first: 11, 3, 7, 9, 1, 5, then indices ≥12 with the higher index winning. Indices 0, 2, 4, 6, 8 and 10 are reserved and never selected.
- **FSM states.**
  - IDLE: if any qualified candidate exists, register the winner's cause and target and go to REQ.
  - REQ: `int_req`=1 and cause/target are frozen, even if a higher-priority source arrives.
    - On `int_ack`, go to HOLD.
    - Else, if the registered source is no longer qualified (line dropped, enable or global bit cleared, mideleg rewritten), withdraw to IDLE.
    - `int_ack` and withdrawal in the same cycle: the ack wins.
  - HOLD: one cycle with `int_req`=0, so the trap unit's mstatus/priv updates settle. Then go to IDLE.
- `int_target_m`/`int_target_s` are mutually exclusive, and both are 0 outside REQ.
- `int_ack` outside REQ is ignored.

## Timing
- **Reset values:** mideleg 0, edge_pend 0, line history 0, state IDLE, `int_req`/`int_target_*` 0, `int_cause` 0.
- **Request latency:** a qualified source at cycle n raises `int_req` at n+1.
- **Back-to-back:** the earliest re-request is 2 cycles after `int_ack` (HOLD, then IDLE evaluation).
- **Withdrawal:** after the qualification loss is visible at cycle n, `int_req` falls at n+1.
- **Reset mid-REQ:** all outputs return to reset values asynchronously, and pending edges are lost.

## Structure
- Package `int_pkg` holds:
  - cause index constants (SSI=1, MSI=3, STI=5, MTI=7, SEI=9, MEI=11);
  - the standard priority order list;
  - the FSM state enum {IDLE, REQ, HOLD}.
- Sub-module `int_prio_sel` (NUM_INT-wide candidate vector in; valid and cause index out) is instantiated twice, once for M candidates and once for S candidates.

## Test plan
- **Reset and mideleg write.** Reset, then write mideleg with data 64'hFFFF.
  - Expect all outputs 0 after reset.
  - Expect `mideleg`=64'h0222 one cycle after the write.
- **M priority.** In U-mode, assert MTI and MEI together with ie=all-ones.
  - Expect `int_req` next cycle, cause {1,11}, `int_target_m`=1.
  - After ack, HOLD, then re-request with cause {1,7}.
- **Delegation.** Set mideleg=0x200 and assert SEI.
  - In S-mode with sie=1: expect `int_target_s`=1, cause {1,9}.
  - In M-mode: expect no request.
  - Then assert MSI while the S request is still unacked: expect the cause stays frozen at 9.
- **Withdrawal.** With a level MTI in REQ, clear `mstatus_mie` while in M-mode and `int_ack`=0.
  - Expect `int_req` to fall one cycle later.
  - Repeat with `int_ack`=1 in that same cycle: expect HOLD, not withdrawal.
- **Edge source.** EDGE_MASK bit 12, pulse `irq_line[12]` for one cycle.
  - Expect the request to persist after the line drops, then clear on ack.
  - A second pulse coinciding with the ack yields a new request after HOLD.
- **Asynchronous reset.** Assert `rst` low mid-REQ between clock edges: expect `int_req`=0 immediately.
